uart_core_fifo: RTL and testbench

Parametrised full-duplex UART for the user project area, replacing the fixed 8N1 single-byte UART. Independent TX and RX paths, each buffered by a synchronous FIFO with valid/ready streaming interfaces. Supports configurable frame format and sticky RX error status. Sits between the Wishbone/LA register shim and mprj_io pins (TX on io[6], RX on io[5]).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_core_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_core_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: parity encodings, shared TX/RX state codes and parity helper.
// Rev 1.0
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Data narrower than 8 bits is zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
    return (mode == 2'(PAR_ODD)) ? ~(^data) : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// uart_sync_fifo: single-clock FIFO with show-ahead read; a push while full is accepted only alongside a pop.
// Rev 1.0
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_core_fifo.sv
`default_nettype none
// uart_core_fifo: parametrised full-duplex UART with FIFO-buffered TX/RX streams and sticky RX errors.
// Rev 1.0
module uart_core_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic                 tx_busy,
  input  logic                 err_clr,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int             CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic           PAR_EN   = (PARITY != PAR_NONE);
  localparam logic [1:0]     PAR_MODE = 2'(PARITY);

  // ---------------- TX path ----------------
  logic                 tx_full, tx_empty, tx_pop, tx_tick, tx_last_stop, tx_line, tx_par, tx_stop_idx;
  logic [DATA_BITS-1:0] tx_head, tx_shift;
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_valid), .push_data(tx_data),
    .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign tx_ready     = !tx_full;
  assign tx_tick      = (tx_cnt == CNT_LAST);
  assign tx_last_stop = tx_tick && ((STOP_BITS == 1) || tx_stop_idx);
  // Popping in the final STOP cycle chains the next frame with no idle gap.
  assign tx_pop       = !tx_empty && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_last_stop));

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_shift[0];
      ST_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_state    <= ST_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      ser_tx      <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      ser_tx  <= tx_line;
      tx_busy <= !tx_empty || (tx_state != ST_IDLE);
      tx_cnt  <= (tx_state == ST_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_shift    <= tx_head;
        tx_par      <= calc_parity(8'(tx_head), PAR_MODE);
        tx_stop_idx <= 1'b0;
        tx_state    <= ST_START;
      end else begin
        case (tx_state)
          ST_START: if (tx_tick) begin
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end
          ST_DATA: if (tx_tick) begin
            tx_shift <= tx_shift >> 1;
            if (tx_bit == BIT_LAST) tx_state <= PAR_EN ? ST_PARITY : ST_STOP;
            else                    tx_bit   <= tx_bit + 1'b1;
          end
          ST_PARITY: if (tx_tick) tx_state <= ST_STOP;
          ST_STOP: if (tx_tick) begin
            if (tx_last_stop) tx_state    <= ST_IDLE;
            else              tx_stop_idx <= 1'b1;
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX path ----------------
  logic                 rx_s1, rx_s2, rx_prev, rx_par_bit;
  logic                 rx_tick, rx_push, rx_pop, rx_full, rx_empty;
  logic                 par_evt, frame_evt, ovr_evt;
  logic [DATA_BITS-1:0] rx_shift;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_bit;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .pop_data(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign rx_valid  = !rx_empty;
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_tick   = (rx_cnt == CNT_LAST);
  assign rx_push   = (rx_state == ST_STOP) && rx_tick;
  assign par_evt   = rx_push && PAR_EN && (calc_parity(8'(rx_shift), PAR_MODE) != rx_par_bit);
  assign frame_evt = rx_push && !rx_s2;
  assign ovr_evt   = rx_push && rx_full && !rx_pop;

  // Edge-triggered arming: after a low stop bit the line must go high again before a new start.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_s1   <= ser_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt  <= rx_cnt + 1'b1;
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= ST_START;
        end
        ST_START: if (rx_cnt == CNT_HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (rx_tick) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BIT_LAST) rx_state <= PAR_EN ? ST_PARITY : ST_STOP;
          else                    rx_bit   <= rx_bit + 1'b1;
        end
        ST_PARITY: if (rx_tick) begin
          rx_cnt     <= '0;
          rx_par_bit <= rx_s2;
          rx_state   <= ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          rx_cnt   <= '0;
          rx_state <= ST_IDLE;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_parity_err <= (rx_parity_err && !err_clr) || par_evt;
      rx_frame_err  <= (rx_frame_err  && !err_clr) || frame_evt;
      rx_overrun    <= (rx_overrun    && !err_clr) || ovr_evt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_fifo.sv
`default_nettype none
// tb_uart_core_fifo: directed vectors and multi-cycle corner sequences for uart_core_fifo.
// Rev 1.0
module tb_uart_core_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: default parameters
  logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, ser_tx_a, ser_rx_a;
  logic       tx_busy_a, err_clr_a, perr_a, ferr_a, ovr_a, loop_a, rx_a;
  logic [7:0] tx_data_a, rx_data_a;
  assign ser_rx_a = loop_a ? ser_tx_a : rx_a;

  // Instance B: 7 data bits, odd parity
  logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, ser_tx_b, ser_rx_b;
  logic       tx_busy_b, err_clr_b, perr_b, ferr_b, ovr_b, loop_b, rx_b;
  logic [6:0] tx_data_b, rx_data_b;
  assign ser_rx_b = loop_b ? ser_tx_b : rx_b;

  uart_core_fifo u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_data(tx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a),
    .ser_tx(ser_tx_a), .ser_rx(ser_rx_a), .tx_busy(tx_busy_a), .err_clr(err_clr_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a)
  );

  uart_core_fifo #(.DATA_BITS(7), .PARITY(2)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_data(tx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b),
    .ser_tx(ser_tx_b), .ser_rx(ser_rx_b), .tx_busy(tx_busy_b), .err_clr(err_clr_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b)
  );

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a 10-bit frame (LSB first, 16 clocks/bit); optional rx_ready / err_clr pulse at cycle offset.
  task automatic drive_line(input int which, input logic [9:0] bits, input int hold,
                            input int pop_at, input int clr_at);
    for (int c = 0; c < 160; c++) begin
      if (which == 0) begin
        rx_a = bits[c/16]; rx_ready_a = (c == pop_at); err_clr_a = (c == clr_at);
      end else begin
        rx_b = bits[c/16]; rx_ready_b = (c == pop_at); err_clr_b = (c == clr_at);
      end
      tick(1);
    end
    rx_ready_a = 1'b0; err_clr_a = 1'b0; rx_ready_b = 1'b0; err_clr_b = 1'b0;
    tick(hold);
    rx_a = 1'b1; rx_b = 1'b1;
    tick(16);
  endtask

  task automatic pop(input int which);
    if (which == 0) rx_ready_a = 1'b1; else rx_ready_b = 1'b1;
    tick(1);
    rx_ready_a = 1'b0; rx_ready_b = 1'b0;
  endtask

  task automatic clr(input int which);
    if (which == 0) err_clr_a = 1'b1; else err_clr_b = 1'b1;
    tick(1);
    err_clr_a = 1'b0; err_clr_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] word;
    logic [7:0] d;

    vecs[0] = '{8'h0F, 1'b1, 0,  8'h0F, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 40, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 0,  8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 0,  8'h80, 1'b1};

    rst = 1'b1;
    tx_valid_a = 1'b0; tx_data_a = '0; rx_ready_a = 1'b0; err_clr_a = 1'b0; loop_a = 1'b0; rx_a = 1'b1;
    tx_valid_b = 1'b0; tx_data_b = '0; rx_ready_b = 1'b0; err_clr_b = 1'b0; loop_b = 1'b0; rx_b = 1'b1;
    tick(3);
    check("rst_ser_tx", ser_tx_a, 1);
    check("rst_tx_ready", tx_ready_a, 1);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_tx_busy", tx_busy_a, 0);
    check("rst_flags", {perr_a, ferr_a, ovr_a}, 0);
    check("rst_ser_tx_b", ser_tx_b, 1);
    rst = 1'b0;
    tick(2);

    // Loopback, two back-to-back bytes
    loop_a = 1'b1;
    tx_valid_a = 1'b1; tx_data_a = 8'h0F;
    tick(1); tx_data_a = 8'h3D;
    tick(1); tx_valid_a = 1'b0;
    check("lb_pre_start", ser_tx_a, 1);
    tick(1);
    check("lb_start_latency", ser_tx_a, 0);
    tick(159);
    check("lb_stop1", ser_tx_a, 1);
    tick(1);
    check("lb_start2_no_gap", ser_tx_a, 0);
    tick(159);
    check("lb_busy_hold", tx_busy_a, 1);
    tick(1);
    check("lb_busy_fall", tx_busy_a, 0);
    check("lb_rx_valid", rx_valid_a, 1);
    check("lb_rx0", rx_data_a, 8'h0F);
    pop(0);
    check("lb_rx1", rx_data_a, 8'h3D);
    pop(0);
    check("lb_rx_empty", rx_valid_a, 0);
    check("lb_flags", {perr_a, ferr_a, ovr_a}, 0);
    loop_a = 1'b0;
    tick(4);

    // Table-driven RX frames, including low stop bits
    for (int i = 0; i < 6; i++) begin
      drive_line(0, {vecs[i].stopb, vecs[i].data, 1'b0}, vecs[i].hold, -1, -1);
      check("vec_valid", rx_valid_a, 1);
      check("vec_data", rx_data_a, vecs[i].exp_data);
      check("vec_ferr", ferr_a, vecs[i].exp_ferr);
      pop(0);
      check("vec_single_push", rx_valid_a, 0);
      clr(0);
      check("vec_ferr_clr", ferr_a, 0);
    end

    // Odd parity, 7 data bits, loopback
    loop_b = 1'b1;
    tx_valid_b = 1'b1; tx_data_b = 7'h55;
    tick(1); tx_valid_b = 1'b0;
    tick(2);
    check("b_start_latency", ser_tx_b, 0);
    tick(8);
    for (int b = 0; b < 10; b++) begin
      word[b] = ser_tx_b;
      tick(16);
    end
    check("b_frame_bits", word, {1'b1, 1'b1, 7'h55, 1'b0});
    check("b_rx_valid", rx_valid_b, 1);
    check("b_rx_data", rx_data_b, 7'h55);
    check("b_perr_clean", perr_b, 0);
    pop(1);
    loop_b = 1'b0;
    tick(4);
    drive_line(1, {1'b1, 1'b0, 7'h55, 1'b0}, 0, -1, -1);
    check("b_perr_set", perr_b, 1);
    check("b_perr_data", rx_data_b, 7'h55);
    pop(1);
    clr(1);
    check("b_perr_clr", perr_b, 0);
    drive_line(1, {1'b1, 1'b0, 7'h55, 1'b0}, 0, -1, 154);
    check("b_set_dominant", perr_b, 1);
    pop(1);
    clr(1);
    check("b_perr_clr2", perr_b, 0);

    // Overrun: five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) drive_line(0, {1'b1, 8'(i), 1'b0}, 0, -1, -1);
    check("ovr_set", ovr_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_pop_data", rx_data_a, i);
      pop(0);
    end
    check("ovr_dropped", rx_valid_a, 0);
    clr(0);
    check("ovr_clr", ovr_a, 0);
    // Full FIFO with a pop in the same cycle as the push
    for (int i = 1; i <= 5; i++) drive_line(0, {1'b1, 8'(i), 1'b0}, 0, (i == 5) ? 154 : -1, -1);
    check("ovr_pop_same_cycle", ovr_a, 0);
    for (int i = 2; i <= 5; i++) begin
      check("ovr2_pop_data", rx_data_a, i);
      pop(0);
    end
    check("ovr2_empty", rx_valid_a, 0);

    // TX FIFO fill while serializer busy
    tx_valid_a = 1'b1; tx_data_a = 8'h11;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      tx_data_a = 8'h11 + 8'(i);
      if (i == 4) check("txf_ready_before", tx_ready_a, 1);
    end
    tick(1);
    tx_valid_a = 1'b0;
    check("txf_full", tx_ready_a, 0);
    tick(6);
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 10; b++) begin
        word[b] = ser_tx_a;
        tick(16);
      end
      d = 8'h11 + 8'(f);
      check("txf_frame", word, {1'b1, d, 1'b0});
    end
    check("txf_busy_done", tx_busy_a, 0);
    check("txf_ready_after", tx_ready_a, 1);
    rx_ready_a = 1'b0;

    // Glitch on the RX line
    rx_a = 1'b0; tick(3); rx_a = 1'b1;
    tick(40);
    check("glitch_no_push", rx_valid_a, 0);
    check("glitch_no_err", {perr_a, ferr_a, ovr_a}, 0);

    // Reset in the middle of a TX frame
    drive_line(0, {1'b0, 8'hA5, 1'b0}, 0, -1, -1);
    check("mr_ferr_pre", ferr_a, 1);
    tx_valid_a = 1'b1; tx_data_a = 8'h00;
    tick(3);
    tx_valid_a = 1'b0;
    tick(41);
    check("mr_tx_low_pre", ser_tx_a, 0);
    rst = 1'b1;
    tick(1);
    check("mr_ser_tx", ser_tx_a, 1);
    check("mr_tx_ready", tx_ready_a, 1);
    check("mr_tx_busy", tx_busy_a, 0);
    check("mr_rx_valid", rx_valid_a, 0);
    check("mr_flags", {perr_a, ferr_a, ovr_a}, 0);
    rst = 1'b0;
    tick(200);
    check("mr_tx_idle_after", ser_tx_a, 1);
    check("mr_busy_after", tx_busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
